lfsr_gen: RTL and testbench

Parametrised pseudo-random sequence generator for the memory-tester game. It produces the random pattern/timing source that drives LED sequencing and the round timeout. It generalises the original 8-bit generator in several ways: width, tap mask, seed, match value and wrap target are configurable, the seed can be loaded at runtime, and run state is visible. It sits between the debounced button-pulse logic and the game controller FSM.

---
 rtl/lfsr_gen.sv | 114 +++++++++++
 tb/tb_lfsr_gen.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Fibonacci XNOR LFSR with a run/idle FSM, runtime
// seed load, a wrap counter and a one-cycle timeout pulse for the game
// controller.
//
// Optional build macro: LFSR_GEN_LOCKUP_FIX_EN
//   defined     - in RUN, an all-ones LFSR is reloaded with SEED on the
//                 next step instead of sitting in the XNOR lockup state.
//   not defined - all-ones is left as a fixed point until seed_load/reset.
module lfsr_gen #(
    parameter int                 WIDTH    = 8,
    parameter logic [WIDTH-1:0]   TAPS     = 8'hB8,
    parameter logic [WIDTH-1:0]   SEED     = '0,
    parameter logic [WIDTH-1:0]   WRAP_VAL = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter logic [WIDTH-1:0]   MATCH    = 8'h61,
    parameter int                 CNT_W    = 11,
    parameter logic [CNT_W-1:0]   WRAP_CNT = 11'd1968
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] lfsr_out,
    output logic             running,
    output logic             lfsr_to,
    output logic [CNT_W-1:0] wrap_cnt
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   lfsr_q, lfsr_d;
    logic [CNT_W-1:0]   wrap_q, wrap_d;
    logic               to_q, to_d;

    logic               is_run;
    logic               hit;
    logic               step_en;
    logic               feedback;
    logic [WIDTH-1:0]   lfsr_step;

    // Decode the current state and the pre-edge conditions used by every decision.
    always_comb begin
        is_run    = (state_q == ST_RUN);
        hit       = is_run && (wrap_q == WRAP_CNT) && (lfsr_q == MATCH);
        step_en   = is_run && !stop;
        feedback  = ~^(lfsr_q & TAPS);
        lfsr_step = {lfsr_q[WIDTH-2:0], feedback};
    end

    // Next-state logic: seed load beats a timeout hit, which beats a normal step.
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        wrap_d  = wrap_q;
        to_d    = 1'b0;

        if (stop) begin
            state_d = ST_IDLE;
        end else if (start) begin
            state_d = ST_RUN;
        end

        if (seed_load) begin
            lfsr_d = seed_in;
            wrap_d = '0;
        end else if (hit) begin
            lfsr_d = SEED;
            wrap_d = '0;
            to_d   = 1'b1;
        end else if (step_en) begin
`ifdef LFSR_GEN_LOCKUP_FIX_EN
            if (&lfsr_q) begin
                lfsr_d = SEED;
            end else begin
                lfsr_d = lfsr_step;
                if (lfsr_q == WRAP_VAL) begin
                    wrap_d = wrap_q + 1'b1;
                end
            end
`else
            lfsr_d = lfsr_step;
            if (lfsr_q == WRAP_VAL) begin
                wrap_d = wrap_q + 1'b1;
            end
`endif
        end
    end

    // State and output registers; reset discards everything asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            lfsr_q  <= SEED;
            wrap_q  <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            wrap_q  <= wrap_d;
            to_q    <= to_d;
        end
    end

    assign lfsr_out = lfsr_q;
    assign running  = (state_q == ST_RUN);
    assign lfsr_to  = to_q;
    assign wrap_cnt = wrap_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen (4-bit configuration, TAPS=4'hC).
// The reference model walks a hand-derived maximal-length ring of states
// rather than computing the XNOR feedback.
module tb_lfsr_gen;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       seed_load;
    logic [3:0] seed_in;
    logic [3:0] lfsr_out;
    logic       running;
    logic       lfsr_to;
    logic [3:0] wrap_cnt;

    int checks;
    int failures;

    // Reference model state
    int m_lfsr;
    int m_wrap;
    bit m_run;
    bit m_to;

    // Period-15 state order for XNOR taps on bits 3 and 2; 4'hF is the lockup state.
    int ring[15] = '{0, 1, 3, 7, 14, 13, 11, 6, 12, 9, 2, 5, 10, 4, 8};

    typedef struct {
        logic       start;
        logic       stop;
        logic       seed_load;
        logic [3:0] seed_in;
        logic [3:0] exp_lfsr;
        logic       exp_run;
        logic       exp_to;
        logic [3:0] exp_wrap;
    } vec_t;

    vec_t vecs[12];

    lfsr_gen #(
        .WIDTH    (4),
        .TAPS     (4'hC),
        .SEED     (4'h0),
        .WRAP_VAL (4'h1),
        .MATCH    (4'h7),
        .CNT_W    (4),
        .WRAP_CNT (4'd2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .lfsr_out  (lfsr_out),
        .running   (running),
        .lfsr_to   (lfsr_to),
        .wrap_cnt  (wrap_cnt)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit so the run can never hang
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int ringNext(input int v);
        for (int i = 0; i < 15; i++) begin
            if (ring[i] == v) return ring[(i + 1) % 15];
        end
        return v;
    endfunction

    // Advance the model by one clock edge using the inputs sampled at that edge
    task automatic modelStep(input bit st, input bit sp, input bit sl, input int si);
        bit hit;
        hit = m_run && (m_wrap == 2) && (m_lfsr == 7);
        if (sl) begin
            m_lfsr = si;
            m_wrap = 0;
            m_to   = 0;
        end else if (hit) begin
            m_lfsr = 0;
            m_wrap = 0;
            m_to   = 1;
        end else begin
            m_to = 0;
            if (m_run && !sp) begin
                if (m_lfsr == 15) begin
`ifdef LFSR_GEN_LOCKUP_FIX_EN
                    m_lfsr = 0;
`endif
                end else begin
                    if (m_lfsr == 1) m_wrap = (m_wrap + 1) % 16;
                    m_lfsr = ringNext(m_lfsr);
                end
            end
        end
        if (sp) m_run = 0;
        else if (st) m_run = 1;
    endtask

    task automatic modelReset();
        m_lfsr = 0;
        m_wrap = 0;
        m_run  = 0;
        m_to   = 0;
    endtask

    task automatic checkVal(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input int e_lfsr, input int e_run,
                               input int e_to, input int e_wrap);
        checkVal({name, ".lfsr_out"}, int'(lfsr_out), e_lfsr);
        checkVal({name, ".running"},  int'(running),  e_run);
        checkVal({name, ".lfsr_to"},  int'(lfsr_to),  e_to);
        checkVal({name, ".wrap_cnt"}, int'(wrap_cnt), e_wrap);
    endtask

    task automatic checkModel(input string name);
        checkOutput(name, m_lfsr, int'(m_run), int'(m_to), m_wrap);
    endtask

    // Drive one set of inputs across one rising edge, then sample 1 ns later
    task automatic applyStimulus(input logic st, input logic sp, input logic sl,
                                 input logic [3:0] si);
        start     = st;
        stop      = sp;
        seed_load = sl;
        seed_in   = si;
        @(posedge clk);
        modelStep(st, sp, sl, int'(si));
        #1;
    endtask

    task automatic doReset();
        start     = 1'b0;
        stop      = 1'b0;
        seed_load = 1'b0;
        seed_in   = 4'h0;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        modelReset();
        checkOutput("reset", 0, 0, 0, 0);
        rst = 1'b0;
    endtask

    initial begin
        int  n;
        bit  found;
        int  lock_exp[3];

        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        modelReset();

        // start, 4 steps, stop/freeze, start+stop, seed load 9 in IDLE, resume
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h1, 1'b1, 1'b0, 4'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h3, 1'b1, 1'b0, 4'd1};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h7, 1'b1, 1'b0, 4'd1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 4'h0, 4'hE, 1'b1, 1'b0, 4'd1};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 4'h0, 4'hE, 1'b0, 1'b0, 4'd1};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 4'h0, 4'hE, 1'b0, 1'b0, 4'd1};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 4'h0, 4'hE, 1'b0, 1'b0, 4'd1};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 4'h9, 4'h9, 1'b0, 1'b0, 4'd0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 4'h0, 4'h9, 1'b1, 1'b0, 4'd0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h2, 1'b1, 1'b0, 4'd0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h5, 1'b1, 1'b0, 4'd0};

        // Table-driven directed vectors
        doReset();
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].start, vecs[i].stop, vecs[i].seed_load, vecs[i].seed_in);
            checkOutput($sformatf("vec%0d", i), int'(vecs[i].exp_lfsr), int'(vecs[i].exp_run),
                        int'(vecs[i].exp_to), int'(vecs[i].exp_wrap));
        end

        // Timeout: two pulses, each 19 edges apart, landing on SEED with wrap 0
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 4'h0);
        checkOutput("to.start", 0, 1, 0, 0);
        for (int p = 0; p < 2; p++) begin
            n = 0;
            found = 0;
            for (int i = 0; i < 60 && !found; i++) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
                n++;
                if (lfsr_to) found = 1;
            end
            checkVal($sformatf("to%0d.found", p), int'(found), 1);
            checkVal($sformatf("to%0d.edges", p), n, 19);
            checkOutput($sformatf("to%0d.pulse", p), 0, 1, 1, 0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
        checkOutput("to.after", 1, 1, 0, 0);

        // Stop after 5 steps, hold 10 idle cycles, resume, then start+stop together
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 4'h0);
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
        checkOutput("stop.pre", 4'hD, 1, 0, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'h0);
        checkOutput("stop.edge", 4'hD, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
            checkOutput($sformatf("stop.idle%0d", i), 4'hD, 0, 0, 1);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 4'h0);
        checkOutput("resume.start", 4'hD, 1, 0, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
        checkOutput("resume.step", 4'hB, 1, 0, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'h0);
        checkOutput("startstop", 4'hB, 0, 0, 1);

        // Seed load while a hit is pending: seed wins, no pulse
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 4'h0);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (lfsr_out == 4'h7 && wrap_cnt == 4'd2) found = 1;
            else applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
        end
        checkVal("pend.reached", int'(found), 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'h9);
        checkOutput("pend.seed", 4'h9, 1, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
        checkOutput("pend.next", 4'h2, 1, 0, 0);

        // Lockup: load all-ones while running and step three times
`ifdef LFSR_GEN_LOCKUP_FIX_EN
        lock_exp = '{0, 1, 3};
`else
        lock_exp = '{15, 15, 15};
`endif
        applyStimulus(1'b0, 1'b0, 1'b1, 4'hF);
        checkOutput("lock.load", 4'hF, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
            checkVal($sformatf("lock%0d.lfsr", i), int'(lfsr_out), lock_exp[i]);
            checkModel($sformatf("lock%0d", i));
        end

        // Asynchronous reset between edges while running
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 4'h0);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
        checkOutput("areset.pre", 4'h7, 1, 0, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("areset", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();

        // Randomised traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(logic'($urandom_range(0, 7) == 0),
                          logic'($urandom_range(0, 15) == 0),
                          logic'($urandom_range(0, 31) == 0),
                          4'($urandom));
            checkModel($sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
